// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus tick-sampled stability filter for WIDTH slide switches.
// Define SW_EDGE_LATCH_EN to add sticky per-bit edgeFlags with a clearFlags input.
module switch_debouncer #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switchesRaw,
`ifdef SW_EDGE_LATCH_EN
    input  logic [WIDTH-1:0] clearFlags,
    output logic [WIDTH-1:0] edgeFlags,
`endif
    output logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] changed
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_switches;
    logic [WIDTH-1:0] r_changed;
    logic [PW-1:0]    r_presc;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic             w_tick;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_accept;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_diff = r_sync2 ^ r_switches;

    // A bit is accepted on the tick that completes STABLE_TICKS consecutive differing samples.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = w_tick && w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switchesRaw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Matching sample or acceptance both return the bit to the stable (zero) count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_switches <= '0;
            r_changed  <= '0;
        end else begin
            r_switches <= r_switches ^ w_accept;
            r_changed  <= w_accept;
        end
    end

    assign switches = r_switches;
    assign changed  = r_changed;

`ifdef SW_EDGE_LATCH_EN
    logic [WIDTH-1:0] r_edge_flags;

    // Set has priority over a simultaneous clear so no movement is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_flags <= '0;
        end else begin
            r_edge_flags <= (r_edge_flags & ~clearFlags) | r_changed;
        end
    end

    assign edgeFlags = r_edge_flags;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a tick-history reference model checked every cycle.
module tb_switch_debouncer;

    localparam int W  = 16;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw = '0;
    logic [W-1:0] clr = '0;
    logic [W-1:0] sw;
    logic [W-1:0] chg;
`ifdef SW_EDGE_LATCH_EN
    logic [W-1:0] ef;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH(W),
        .TICK_DIV(TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switchesRaw(raw),
`ifdef SW_EDGE_LATCH_EN
        .clearFlags(clr),
        .edgeFlags(ef),
`endif
        .switches(sw),
        .changed(chg)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: keeps every tick sample since reset; a bit flips when the last
    // ST samples all disagree with its accepted level and ST ticks have passed since
    // its previous acceptance.
    bit           mv = 1'b0;
    int           p;
    logic [W-1:0] m_s1, m_s2, m_lvl, m_chg, m_ef;
    logic [W-1:0] hist[$];
    int           last_acc[W];

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_chg = '0; m_ef = '0;
            p = 1;
            hist.delete();
            for (int i = 0; i < W; i++) last_acc[i] = -1;
            mv = 1'b1;
        end else begin
            m_ef  = (m_ef & ~clr) | m_chg;
            m_chg = '0;
            if (p % TD == 0) begin
                int k;
                hist.push_back(m_s2);
                k = hist.size() - 1;
                for (int i = 0; i < W; i++) begin
                    if (k - last_acc[i] >= ST) begin
                        bit ok;
                        ok = 1'b1;
                        for (int j = 0; j < ST; j++) begin
                            logic [W-1:0] hv;
                            hv = hist[k-j];
                            if (hv[i] == m_lvl[i]) ok = 1'b0;
                        end
                        if (ok) begin
                            m_chg[i] = 1'b1;
                            last_acc[i] = k;
                        end
                    end
                end
                m_lvl = m_lvl ^ m_chg;
            end
            m_s2 = m_s1;
            m_s1 = raw;
            p++;
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("cyc_switches", sw, m_lvl);
            chk("cyc_changed", chg, m_chg);
`ifdef SW_EDGE_LATCH_EN
            chk("cyc_edgeFlags", ef, m_ef);
`endif
        end
    end

    task automatic wait_bit(input int b, input int budget, output int n,
                            output logic [W-1:0] c_at, output logic [W-1:0] s_at);
        n = -1;
        c_at = '0;
        s_at = '0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (chg[b]) begin
                n = c;
                c_at = chg;
                s_at = sw;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulses, rises, falls, bad;
        logic [W-1:0] pv, cat, sat;
        logic prev;

        // Case 1: reset with all switches high, then release.
        rst = 1'b1;
        raw = '1;
        repeat (3) @(negedge clk);
        chk("t1_rst_switches", sw, '0);
        chk("t1_rst_changed", chg, '0);
        rst = 1'b0;
        n = 0; pulses = 0; pv = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (n == 0 && sw != '0) n = c;
            if (chg != '0) begin
                pulses++;
                pv = chg;
            end
        end
        chk("t1_latency", W'(n), W'(12));
        chk("t1_pulses", W'(pulses), W'(1));
        chk("t1_pulse_val", pv, 16'hFFFF);
        chk("t1_final", sw, 16'hFFFF);

        // Case 2: clean rising edge on bit 0 from steady zero.
        raw = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_steady", sw, '0);
        raw[0] = 1'b1;
        wait_bit(0, 30, n, cat, sat);
        chk("t2_latency_in_range", W'(n >= 11 && n <= 14), W'(1));
        chk("t2_changed", cat, 16'h0001);
        chk("t2_switches", sat, 16'h0001);
        @(negedge clk);
        chk("t2_pulse_end", chg, '0);

`ifdef SW_EDGE_LATCH_EN
        // Case 6: sticky flag, clear, and set-beats-clear.
        chk("t6_flag_set", ef, 16'h0001);
        repeat (5) @(negedge clk);
        chk("t6_flag_hold", ef, 16'h0001);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("t6_flag_clr", ef, '0);
        raw[0] = 1'b0;
        wait_bit(0, 30, n, cat, sat);
        chk("t6_fall_seen", W'(n > 0), W'(1));
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("t6_set_wins", ef, 16'h0001);
        raw[0] = 1'b1;
        wait_bit(0, 30, n, cat, sat);
        chk("t6_restore", W'(n > 0), W'(1));
        @(negedge clk);
`endif

        // Case 3: six-cycle glitch on bit 3 must be rejected.
        bad = 0;
        raw[3] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (sw[3] || chg[3]) bad++;
        end
        raw[3] = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (sw[3] || chg[3]) bad++;
        end
        chk("t3_glitch", W'(bad), W'(0));

        // Case 4: per-cycle bounce on bit 5, then settle high.
        rises = 0; falls = 0; pulses = 0;
        prev = sw[5];
        for (int c = 0; c < 40; c++) begin
            if (c < 10) raw[5] = ~raw[5];
            else raw[5] = 1'b1;
            @(negedge clk);
            if (sw[5] && !prev) rises++;
            if (!sw[5] && prev) falls++;
            if (chg[5]) pulses++;
            prev = sw[5];
        end
        chk("t4_rises", W'(rises), W'(1));
        chk("t4_falls", W'(falls), W'(0));
        chk("t4_pulses", W'(pulses), W'(1));
        chk("t4_final", W'(sw[5]), W'(1));

        // Case 5a: bits 1 and 2 rise together.
        raw[2:1] = 2'b11;
        n = -1; pv = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if ((chg & 16'h0006) != '0) begin
                n = c;
                pv = chg & 16'h0006;
                break;
            end
        end
        chk("t5_same_cycle", pv, 16'h0006);
        @(negedge clk);
        chk("t5_pulse_end", chg & 16'h0006, '0);

        // Case 5b: reset five cycles into a pending change discards it.
        raw = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        raw[2:1] = 2'b11;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (chg != '0) pulses++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (chg != '0) pulses++;
        end
        chk("t5_rst_switches", sw, '0);
        rst = 1'b0;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (n == 0 && sw != '0) n = c;
        end
        chk("t5_no_pulse", W'(pulses), W'(0));
        chk("t5_relatency", W'(n), W'(12));
        chk("t5_final", sw, 16'h0006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
